// File: rtl/tinker_pkg.sv
// Shared types for the Tinker execute-stage multiply/divide unit.
package tinker_pkg;

  typedef enum logic [1:0] {
    MUL  = 2'd0,
    MULH = 2'd1,
    DIV  = 2'd2,
    REM  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/tinker_muldiv_if.sv
// Request/response handshake bundle between execute and the multiply/divide unit.
interface tinker_muldiv_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
);
  import tinker_pkg::*;

  logic             in_valid;
  logic             in_ready;
  md_op_e           in_op;
  logic             in_signed;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             kill;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, in_op, in_signed, in_a, in_b, in_tag, kill, out_ready,
    input  in_ready, out_valid, out_result, out_tag, busy
  );

  modport slave (
    input  in_valid, in_op, in_signed, in_a, in_b, in_tag, kill, out_ready,
    output in_ready, out_valid, out_result, out_tag, busy
  );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step
  import tinker_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  md_op_e          op,
  input  logic [XLEN:0]   part,
  input  logic [XLEN-1:0] shift,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN:0]   part_next,
  output logic [XLEN-1:0] shift_next,
  output logic            q_bit
);

  logic [XLEN:0] addend;
  logic [XLEN:0] sum;
  logic [XLEN:0] rem_shift;
  logic [XLEN:0] diff;

  // part holds the product high half or the running remainder; shift holds the
  // multiplier/dividend bits still to be consumed.
  always_comb begin
    addend     = '0;
    sum        = '0;
    rem_shift  = {part[XLEN-1:0], shift[XLEN-1]};
    diff       = rem_shift - {1'b0, operand};
    part_next  = part;
    shift_next = shift;
    q_bit      = 1'b0;
    if (op == DIV || op == REM) begin
      q_bit      = (rem_shift >= {1'b0, operand});
      part_next  = q_bit ? diff : rem_shift;
      shift_next = {shift[XLEN-2:0], 1'b0};
    end else begin
      addend     = shift[0] ? {1'b0, operand} : '0;
      sum        = part + addend;
      part_next  = {1'b0, sum[XLEN:1]};
      shift_next = {sum[0], shift[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/tinker_muldiv.sv
// Iterative multiply/divide unit: one bit per cycle, sign fix-up, tagged valid/ready result.
module tinker_muldiv
  import tinker_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input logic            clk,
  input logic            reset,
  tinker_muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  md_op_e           op;
  logic             neg_res;
  logic             neg_rem;
  logic [XLEN-1:0]  operand;
  logic [XLEN:0]    part;
  logic [XLEN-1:0]  shift;
  logic [TAG_W-1:0] tag;

  logic [XLEN:0]    part_next;
  logic [XLEN-1:0]  shift_next;
  logic             q_bit;

  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic [XLEN-1:0]  a_mag;
  logic [XLEN-1:0]  b_mag;
  logic             req_div;
  logic             div_zero;
  logic             div_ovf;
  logic [XLEN-1:0]  special_result;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]  fix_result;

  assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign accept        = bus.in_valid && bus.in_ready && !bus.kill;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .op         (op),
    .part       (part),
    .shift      (shift),
    .operand    (operand),
    .part_next  (part_next),
    .shift_next (shift_next),
    .q_bit      (q_bit)
  );

  // Divide-by-zero and MIN/-1 bypass the engine with a fixed result.
  always_comb begin
    a_neg    = bus.in_signed & bus.in_a[XLEN-1];
    b_neg    = bus.in_signed & bus.in_b[XLEN-1];
    a_mag    = a_neg ? -bus.in_a : bus.in_a;
    b_mag    = b_neg ? -bus.in_b : bus.in_b;
    req_div  = (bus.in_op == DIV) || (bus.in_op == REM);
    div_zero = req_div && (bus.in_b == '0);
    div_ovf  = req_div && bus.in_signed && (bus.in_a == MIN_VAL) && (bus.in_b == '1);
    special_result = '0;
    if (div_zero)
      special_result = (bus.in_op == DIV) ? '1 : bus.in_a;
    else if (bus.in_op == DIV)
      special_result = MIN_VAL;
  end

  always_comb begin
    prod = {part[XLEN-1:0], shift};
    if (neg_res)
      prod = -prod;
    case (op)
      MUL:     fix_result = prod[XLEN-1:0];
      MULH:    fix_result = prod[2*XLEN-1:XLEN];
      DIV:     fix_result = neg_res ? -shift : shift;
      default: fix_result = neg_rem ? -part[XLEN-1:0] : part[XLEN-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      op             <= MUL;
      neg_res        <= 1'b0;
      neg_rem        <= 1'b0;
      operand        <= '0;
      part           <= '0;
      shift          <= '0;
      tag            <= '0;
      bus.out_result <= '0;
      bus.out_tag    <= '0;
    end else if (bus.kill) begin
      state <= IDLE;
    end else if (accept) begin
      op      <= bus.in_op;
      tag     <= bus.in_tag;
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      operand <= b_mag;
      part    <= '0;
      shift   <= a_mag;
      cnt     <= '0;
      if (div_zero || div_ovf) begin
        bus.out_result <= special_result;
        bus.out_tag    <= bus.in_tag;
        state          <= DONE;
      end else begin
        state <= BUSY;
      end
    end else begin
      case (state)
        BUSY: begin
          part  <= part_next;
          // The quotient bit enters at the bottom as the dividend shifts out the top.
          shift <= (op == DIV || op == REM) ? {shift_next[XLEN-1:1], q_bit} : shift_next;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(XLEN-1))
            state <= FIX;
        end
        FIX: begin
          bus.out_result <= fix_result;
          bus.out_tag    <= tag;
          state          <= DONE;
        end
        DONE: begin
          if (bus.out_ready)
            state <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tinker_muldiv.sv
// Directed-vector bench for tinker_muldiv at XLEN=64 and XLEN=8.
module tb_tinker_muldiv;
  import tinker_pkg::*;

  typedef struct {
    string         name;
    bit            narrow;
    md_op_e        op;
    bit            sgn;
    logic [63:0]   a;
    logic [63:0]   b;
    logic [63:0]   exp;
    int            lat;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];

  tinker_muldiv_if #(.XLEN(64), .TAG_W(5)) bus64 ();
  tinker_muldiv_if #(.XLEN(8),  .TAG_W(5)) bus8 ();

  tinker_muldiv #(.XLEN(64), .TAG_W(5)) dut64 (.clk(clk), .reset(reset), .bus(bus64));
  tinker_muldiv #(.XLEN(8),  .TAG_W(5)) dut8  (.clk(clk), .reset(reset), .bus(bus8));

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic addVec(input string name, input bit narrow, input md_op_e op, input bit sgn,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp, input int lat);
    vec_t v;
    v.name = name; v.narrow = narrow; v.op = op; v.sgn = sgn;
    v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Presents one request for a single edge; returns #1 after the accept edge.
  task automatic applyStimulus(input bit narrow, input md_op_e op, input bit sgn,
                               input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag);
    if (narrow) begin
      bus8.in_valid = 1'b1; bus8.in_op = op; bus8.in_signed = sgn;
      bus8.in_a = a[7:0]; bus8.in_b = b[7:0]; bus8.in_tag = tag;
    end else begin
      bus64.in_valid = 1'b1; bus64.in_op = op; bus64.in_signed = sgn;
      bus64.in_a = a; bus64.in_b = b; bus64.in_tag = tag;
    end
    @(posedge clk); #1;
    bus8.in_valid  = 1'b0;
    bus64.in_valid = 1'b0;
  endtask

  task automatic waitResult(input bit narrow, output logic [63:0] res, output logic [4:0] tag, output int lat);
    lat = 1;
    while (!(narrow ? bus8.out_valid : bus64.out_valid) && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    res = narrow ? {56'd0, bus8.out_result} : bus64.out_result;
    tag = narrow ? bus8.out_tag : bus64.out_tag;
  endtask

  task automatic consume();
    bus8.out_ready  = 1'b1;
    bus64.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready  = 1'b0;
    bus64.out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] res;
    logic [4:0]  rtag;
    int          lat;
    int          seen;

    bus64.in_valid = 0; bus64.in_op = MUL; bus64.in_signed = 0; bus64.in_a = '0; bus64.in_b = '0;
    bus64.in_tag = '0; bus64.kill = 0; bus64.out_ready = 0;
    bus8.in_valid = 0; bus8.in_op = MUL; bus8.in_signed = 0; bus8.in_a = '0; bus8.in_b = '0;
    bus8.in_tag = '0; bus8.kill = 0; bus8.out_ready = 0;

    #22;
    checkOutput("rst_in_ready",  bus64.in_ready,   1);
    checkOutput("rst_out_valid", bus64.out_valid,  0);
    checkOutput("rst_busy",      bus64.busy,       0);
    checkOutput("rst_result",    bus64.out_result, 0);
    checkOutput("rst_tag",       bus64.out_tag,    0);
    reset = 1'b1;
    @(posedge clk); #1;

    addVec("mul_u_7x6",      0, MUL,  0, 64'd7, 64'd6, 64'd42, 66);
    addVec("mulh_s_min_x2",  0, MULH, 1, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    addVec("mul_s_m3x5",     0, MUL,  1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 66);
    addVec("mulh_u_max",     0, MULH, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    addVec("div_s_m7d2",     0, DIV,  1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    addVec("rem_s_m7d2",     0, REM,  1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    addVec("div_s_7dm2",     0, DIV,  1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    addVec("rem_s_7dm2",     0, REM,  1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 66);
    addVec("div_u_100d7",    0, DIV,  0, 64'd100, 64'd7, 64'd14, 66);
    addVec("rem_u_100d7",    0, REM,  0, 64'd100, 64'd7, 64'd2, 66);
    addVec("div_5d0",        0, DIV,  0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    addVec("rem_5d0",        0, REM,  0, 64'd5, 64'd0, 64'd5, 1);
    addVec("div_s_min_dm1",  0, DIV,  1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
    addVec("rem_s_min_dm1",  0, REM,  1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    addVec("n8_mul_u_7x6",   1, MUL,  0, 64'd7, 64'd6, 64'd42, 10);
    addVec("n8_mulh_u_200x3",1, MULH, 0, 64'd200, 64'd3, 64'h02, 10);
    addVec("n8_mul_s_m3x5",  1, MUL,  1, 64'hFD, 64'd5, 64'hF1, 10);
    addVec("n8_mulh_s_min2", 1, MULH, 1, 64'h80, 64'd2, 64'hFF, 10);
    addVec("n8_div_u_200d3", 1, DIV,  0, 64'd200, 64'd3, 64'd66, 10);
    addVec("n8_rem_u_200d3", 1, REM,  0, 64'd200, 64'd3, 64'd2, 10);
    addVec("n8_div_s_m7d2",  1, DIV,  1, 64'hF9, 64'd2, 64'hFD, 10);
    addVec("n8_div_5d0",     1, DIV,  0, 64'd5, 64'd0, 64'hFF, 1);
    addVec("n8_div_min_m1",  1, DIV,  1, 64'h80, 64'hFF, 64'h80, 1);
    addVec("n8_rem_min_m1",  1, REM,  1, 64'h80, 64'hFF, 64'h00, 1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].narrow, vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, 5'(i + 1));
      waitResult(vecs[i].narrow, res, rtag, lat);
      checkOutput({vecs[i].name, "_res"}, res, vecs[i].exp);
      checkOutput({vecs[i].name, "_tag"}, 64'(rtag), 64'(i + 1));
      checkOutput({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].lat));
      consume();
    end

    // Back-pressure: result and tag held while out_ready stays low.
    applyStimulus(0, MUL, 0, 64'd3, 64'd4, 5'd3);
    waitResult(0, res, rtag, lat);
    checkOutput("bp_res", res, 64'd12);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("bp_hold_res%0d", i),   bus64.out_result, 64'd12);
      checkOutput($sformatf("bp_hold_tag%0d", i),   64'(bus64.out_tag), 64'd3);
      checkOutput($sformatf("bp_hold_valid%0d", i), bus64.out_valid, 1);
      checkOutput($sformatf("bp_hold_ready%0d", i), bus64.in_ready, 0);
    end
    bus64.out_ready = 1'b1;
    bus64.in_valid  = 1'b1; bus64.in_op = DIV; bus64.in_signed = 1'b0;
    bus64.in_a = 64'd100; bus64.in_b = 64'd7; bus64.in_tag = 5'd4;
    #1;
    checkOutput("bp_in_ready", bus64.in_ready, 1);
    @(posedge clk); #1;
    bus64.in_valid = 1'b0; bus64.out_ready = 1'b0;
    checkOutput("bp_busy_after", bus64.busy, 1);
    checkOutput("bp_valid_after", bus64.out_valid, 0);
    waitResult(0, res, rtag, lat);
    checkOutput("bp_next_res", res, 64'd14);
    checkOutput("bp_next_tag", 64'(rtag), 64'd4);
    checkOutput("bp_next_lat", 64'(lat), 64'd66);
    consume();

    // Kill in the 20th BUSY cycle.
    applyStimulus(0, MUL, 0, 64'd7, 64'd6, 5'd7);
    repeat (19) begin @(posedge clk); #1; end
    bus64.kill = 1'b1;
    @(posedge clk); #1;
    bus64.kill = 1'b0;
    checkOutput("kill_busy", bus64.busy, 0);
    checkOutput("kill_valid", bus64.out_valid, 0);
    checkOutput("kill_in_ready", bus64.in_ready, 1);
    seen = 0;
    repeat (70) begin @(posedge clk); #1; if (bus64.out_valid) seen++; end
    checkOutput("kill_no_valid", 64'(seen), 0);

    // Kill wins over a simultaneous request.
    bus64.kill = 1'b1; bus64.in_valid = 1'b1; bus64.in_op = MUL; bus64.in_a = 64'd2; bus64.in_b = 64'd2;
    @(posedge clk); #1;
    bus64.kill = 1'b0; bus64.in_valid = 1'b0;
    checkOutput("kill_prio_busy", bus64.busy, 0);

    // Asynchronous reset mid-BUSY.
    applyStimulus(0, MUL, 0, 64'd9, 64'd9, 5'd9);
    repeat (10) begin @(posedge clk); #1; end
    #2 reset = 1'b0;
    #1;
    checkOutput("arst_busy", bus64.busy, 0);
    checkOutput("arst_valid", bus64.out_valid, 0);
    checkOutput("arst_in_ready", bus64.in_ready, 1);
    checkOutput("arst_result", bus64.out_result, 0);
    checkOutput("arst_tag", 64'(bus64.out_tag), 0);
    #3 reset = 1'b1;
    seen = 0;
    repeat (80) begin @(posedge clk); #1; if (bus64.out_valid) seen++; end
    checkOutput("arst_no_valid", 64'(seen), 0);

    applyStimulus(0, MUL, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFA, 5'd11);
    waitResult(0, res, rtag, lat);
    checkOutput("post_rst_mul_res", res, 64'd42);
    checkOutput("post_rst_mul_lat", 64'(lat), 64'd66);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
